// File: rtl/clk_pkg.sv
// -----------------------------------------------------------------------------
// clk_pkg
// Shared definitions for the PLL lock sequencer: the sequencer state enum,
// default timing constants and a small saturating-increment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package clk_pkg;

    // Sequencer states, in the order the bring-up normally walks through them.
    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } lock_state_t;

    localparam int LOCK_STABLE_DEF    = 1024;
    localparam int LOCK_TIMEOUT_DEF   = 65536;
    localparam int PLL_RST_CYCLES_DEF = 16;
    localparam int DIV_DEF            = 4;

    // Event counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level into the i_clk domain.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset, clears both flops
//   i_d     - asynchronous input level
//   o_q     - synchronized level, two i_clk cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
// Brings a PLL out of reset, waits for a stable lock and then releases the
// downstream system reset and a divided clock enable. Lock loss drops the
// system back into reset; a lock that never arrives re-pulses the PLL reset.
// Ports:
//   clk           - fast system clock (PLL output), the only clock
//   rst_n         - asynchronous active-low reset
//   pll_locked    - PLL lock indication, asynchronous to clk
//   pll_rst       - active-high reset to the PLL
//   sys_rst_n     - active-low downstream reset, high only in RUN
//   ce            - one-cycle clock enable every DIV cycles in RUN
//   ce_phase      - position within the DIV period, 0 outside RUN
//   lock_lost_cnt - saturating count of lock losses seen in RUN
//   timeout_cnt   - saturating count of lock timeouts
// -----------------------------------------------------------------------------
module pll_lock_sequencer
    import clk_pkg::*;
#(
    parameter int LOCK_STABLE    = LOCK_STABLE_DEF,
    parameter int LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
    parameter int PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
    parameter int DIV            = DIV_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   pll_locked,
    output logic                                   pll_rst,
    output logic                                   sys_rst_n,
    output logic                                   ce,
    output logic [((DIV > 1) ? $clog2(DIV) : 1)-1:0] ce_phase,
    output logic [7:0]                             lock_lost_cnt,
    output logic [7:0]                             timeout_cnt
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    // One counter serves all timed states, so size it for the longest one.
    localparam int CNT_MAX_A = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int CNT_MAX   = (CNT_MAX_A > PLL_RST_CYCLES) ? CNT_MAX_A : PLL_RST_CYCLES;
    localparam int CW        = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] C_RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] C_STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [PW-1:0] C_PHASE_LAST   = PW'(DIV - 1);

    lock_state_t   r_state;
    lock_state_t   w_next_state;
    logic [CW-1:0] r_cnt;
    logic          w_lock_s;
    logic          w_timeout_hit;
    logic          w_lock_lost;
    logic          w_run_next;
    logic [PW-1:0] w_phase_next;

    sync_2ff u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (pll_locked),
        .o_q     (w_lock_s)
    );

    // Next-state decisions. A falling lock is tested before any terminal
    // count so that losing lock always wins over a timeout or a release.
    always_comb begin
        w_next_state  = r_state;
        w_timeout_hit = 1'b0;
        w_lock_lost   = 1'b0;
        unique case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == C_RST_LAST) begin
                    w_next_state = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next_state = ST_STABLE;
                end else if (r_cnt == C_TIMEOUT_LAST) begin
                    w_next_state  = ST_PLL_RST;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_lock_lost  = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_PLL_RST;
            end
        endcase
    end

    // Enable phase for the coming cycle: restarts at 0 on every RUN entry.
    always_comb begin
        w_run_next   = (w_next_state == ST_RUN);
        w_phase_next = '0;
        if (w_run_next && (r_state == ST_RUN)) begin
            w_phase_next = (ce_phase == C_PHASE_LAST) ? '0 : ce_phase + 1'b1;
        end
    end

    // State and shared counter; the counter is cleared on every state entry
    // and parked at zero in RUN, where nothing is timed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PLL_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || w_run_next) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they line up exactly
    // with the registered state, with no decode glitches at the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ce            <= 1'b0;
            ce_phase      <= '0;
            lock_lost_cnt <= 8'd0;
            timeout_cnt   <= 8'd0;
        end else begin
            pll_rst   <= (w_next_state == ST_PLL_RST);
            sys_rst_n <= w_run_next;
            ce        <= w_run_next && (w_phase_next == C_PHASE_LAST);
            ce_phase  <= w_phase_next;
            if (w_lock_lost) begin
                lock_lost_cnt <= sat_inc8(lock_lost_cnt);
            end
            if (w_timeout_hit) begin
                timeout_cnt <= sat_inc8(timeout_cnt);
            end
        end
    end

endmodule
